// File: rtl/radio.sv
// Half-duplex serial radio front end: LSB-first byte TX on Tx, level-gated byte RX on Rx.
// Define RADIO_PARITY_EN to append/check an even parity bit after the payload.
module radio #(
   parameter int CLKS_PER_BIT = 1,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              send,
   output logic              busy,
   input  logic              receive,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              Tx,
   input  logic              Rx
);

`ifdef RADIO_PARITY_EN
   localparam int FRAME_W = DATA_W + 1;
`else
   localparam int FRAME_W = DATA_W;
`endif
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SAMPLE_CLK = CW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_W - 1);

   typedef enum logic [1:0] {IDLE, TX, RX} state_t;

   state_t             state;
   logic [CW-1:0]      clk_cnt;
   logic [BW-1:0]      bit_cnt;
   logic [FRAME_W-2:0] tx_shift;
   logic [FRAME_W-2:0] rx_shift;
   logic [FRAME_W-1:0] tx_frame;
   logic [FRAME_W-1:0] rx_frame;
   logic               rx_ok;

   // rx_frame is the complete frame as it would stand after sampling Rx this edge
   always_comb begin
      rx_frame = {Rx, rx_shift};
`ifdef RADIO_PARITY_EN
      tx_frame = {^tx_data, tx_data};
      rx_ok    = ((^rx_frame[DATA_W-1:0]) == rx_frame[DATA_W]);
`else
      tx_frame = tx_data;
      rx_ok    = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         Tx       <= 1'b1;
         busy     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (!enable) begin
            state   <= IDLE;
            Tx      <= 1'b1;
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  Tx      <= 1'b1;
                  if (send) begin
                     state    <= TX;
                     busy     <= 1'b1;
                     Tx       <= tx_frame[0];
                     tx_shift <= tx_frame[FRAME_W-1:1];
                  end else if (receive) begin
                     state <= RX;
                     busy  <= 1'b1;
                  end
               end
               TX: begin
                  if (clk_cnt == LAST_CLK) begin
                     clk_cnt <= '0;
                     if (bit_cnt == LAST_BIT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        Tx    <= 1'b1;
                     end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        Tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                     end
                  end else begin
                     clk_cnt <= clk_cnt + 1'b1;
                  end
               end
               RX: begin
                  if (!receive) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     clk_cnt <= (clk_cnt == LAST_CLK) ? '0 : clk_cnt + 1'b1;
                     if (clk_cnt == SAMPLE_CLK) begin
                        rx_shift <= rx_frame[FRAME_W-1:1];
                        if (bit_cnt == LAST_BIT) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           if (rx_ok) begin
                              rx_data  <= rx_frame[DATA_W-1:0];
                              rx_valid <= 1'b1;
                           end
                        end else begin
                           bit_cnt <= bit_cnt + 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  Tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_radio.sv
// Randomised self-checking bench for radio; expected serial streams and received
// bytes come from a bit-list model of the frame format.
module tb_radio;

   localparam int CPB = 1;
   localparam int DW  = 8;
`ifdef RADIO_PARITY_EN
   localparam int FB = DW + 1;
`else
   localparam int FB = DW;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          send;
   logic          receive;
   logic          Rx;
   logic [DW-1:0] tx_data;
   logic          busy;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          Tx;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] exp_rx_data = '0;

   radio #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .send     (send),
      .busy     (busy),
      .receive  (receive),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .Tx       (Tx),
      .Rx       (Rx)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Serial bit i of the frame carrying payload d
   function automatic logic frame_bit(input logic [DW-1:0] d, input int i);
      if (i < DW) return d[i];
      return ^d;
   endfunction

   function automatic logic [FB-1:0] make_frame(input logic [DW-1:0] d);
      logic [FB-1:0] f;
      f = '0;
      for (int i = 0; i < FB; i++) f[i] = frame_bit(d, i);
      return f;
   endfunction

   task automatic idle_check(input string tag);
      check({tag, "_tx"}, Tx, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_rxv"}, rx_valid, 1'b0);
      check({tag, "_rxd"}, rx_data, exp_rx_data);
   endtask

   // cut_at >= 0: interrupt in cycle cut_at, by reset when cut_rst else by enable=0
   task automatic run_tx(input logic [DW-1:0] d, input bit with_rx, input int cut_at, input bit cut_rst);
      @(negedge clk);
      enable = 1'b1; send = 1'b1; receive = with_rx; tx_data = d;
      for (int i = 0; i < FB*CPB; i++) begin
         @(negedge clk);
         check("tx_bit", Tx, frame_bit(d, i / CPB));
         check("tx_busy", busy, 1'b1);
         check("tx_rxv", rx_valid, 1'b0);
         if (i == cut_at) begin
            send = 1'b0; receive = 1'b0;
            if (cut_rst) begin
               rst = 1'b1;
               #1;
               exp_rx_data = '0;
               check("rst_tx", Tx, 1'b1);
               check("rst_busy", busy, 1'b0);
               check("rst_rxd", rx_data, 8'h00);
               check("rst_rxv", rx_valid, 1'b0);
               @(negedge clk);
               rst = 1'b0;
            end else begin
               enable = 1'b0;
               @(negedge clk);
               check("dis_tx", Tx, 1'b1);
               check("dis_busy", busy, 1'b0);
               enable = 1'b1;
            end
            return;
         end
         send = 1'($urandom_range(0, 1));
         receive = 1'($urandom_range(0, 1));
         tx_data = DW'($urandom);
         Rx = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      send = 1'b0; receive = 1'b0;
      idle_check("tx_end");
   endtask

   // Bit k of the frame is held on Rx for its whole bit period; cut_at drops receive early
   task automatic run_rx(input logic [FB-1:0] bits, input int cut_at);
      int  last;
      bit  good;
      last = (FB - 1) * CPB + CPB / 2;
      @(negedge clk);
      enable = 1'b1; send = 1'b0; receive = 1'b1;
      for (int m = 0; m <= last; m++) begin
         @(negedge clk);
         check("rx_busy", busy, 1'b1);
         check("rx_tx", Tx, 1'b1);
         check("rx_rxv", rx_valid, 1'b0);
         if (m == cut_at) begin
            receive = 1'b0; send = 1'b0;
            @(negedge clk);
            idle_check("rx_abort");
            return;
         end
         Rx = bits[m / CPB];
         send = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      send = 1'b0; receive = 1'b0;
`ifdef RADIO_PARITY_EN
      good = ((^bits) == 1'b0);
`else
      good = 1'b1;
`endif
      if (good) exp_rx_data = bits[DW-1:0];
      check("rx_valid", rx_valid, good);
      check("rx_data", rx_data, exp_rx_data);
      check("rx_end_busy", busy, 1'b0);
      @(negedge clk);
      check("rx_pulse", rx_valid, 1'b0);
   endtask

   initial begin
      logic [FB-1:0] f;
      rst = 1'b1; enable = 1'b0; send = 1'b0; receive = 1'b0; Rx = 1'b1; tx_data = '0;
      repeat (2) @(negedge clk);
      idle_check("reset");
      rst = 1'b0;
      @(negedge clk);
      idle_check("post_reset");

      run_tx(8'hAA, 1'b0, -1, 1'b0);
      run_rx(make_frame(8'h4D), -1);
      run_rx(make_frame(8'hF0), 4);
      run_tx(8'h5C, 1'b1, -1, 1'b0);
      run_tx(8'h3C, 1'b0, 3, 1'b0);
      run_tx(8'h07, 1'b0, -1, 1'b0);
`ifdef RADIO_PARITY_EN
      f = make_frame(8'h96);
      f[FB-1] = ~f[FB-1];
      run_rx(f, -1);
`endif

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0: run_tx(DW'($urandom), 1'($urandom_range(0, 1)), -1, 1'b0);
            1: begin
               f = make_frame(DW'($urandom));
`ifdef RADIO_PARITY_EN
               if ($urandom_range(0, 3) == 0) f[FB-1] = ~f[FB-1];
`endif
               run_rx(f, -1);
            end
            2: run_rx(make_frame(DW'($urandom)), $urandom_range(0, (FB-1)*CPB + CPB/2));
            3: run_tx(DW'($urandom), 1'b0, $urandom_range(0, FB*CPB - 1), 1'b0);
            default: begin
               @(negedge clk);
               enable = 1'b0; send = 1'b1; receive = 1'b1;
               @(negedge clk);
               idle_check("disabled");
               enable = 1'b1; send = 1'b0; receive = 1'b0;
            end
         endcase
      end

      run_rx(make_frame(8'hC3), -1);
      run_tx(DW'($urandom), 1'b0, 2, 1'b1);
      @(negedge clk);
      idle_check("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
